// File: rtl/cla_pg_stage.sv
// cla_pg_stage: propagate/generate front end of a carry-lookahead adder.
// Each accepted operand pair is reduced to per-bit propagate (a^b) and
// generate (a&b), stored with its carry-in in a 2-entry FIFO, and the head
// entry is presented to the carry generator together with its group
// propagate and group generate terms.
// Optional feature: define CLA_PG_STALL_CNT_EN to add a 16-bit saturating
// stall counter output (cycles with out_valid=1 and out_ready=0).
`timescale 1ns/1ps

module cla_pg_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] p,
   output logic [WIDTH-1:0] g,
   output logic             c0,
   output logic             gp,
   output logic             gg
`ifdef CLA_PG_STALL_CNT_EN
   ,
   output logic [15:0]      stall_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             armed;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] p_new;
   logic [WIDTH-1:0] g_new;

   // Slot 0 is always the head; slot 1 holds the second-oldest entry.
   logic [WIDTH-1:0] p_mem [2];
   logic [WIDTH-1:0] g_mem [2];
   logic             c_mem [2];

   logic             gg_head;

   // armed keeps in_ready low until the first edge after reset release,
   // so that edge can never accept a transfer.
   assign in_ready  = armed && (state != FULL);
   assign out_valid = (state != EMPTY);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign p_new     = a ^ b;
   assign g_new     = a & b;

   // Occupancy transitions: push advances, pop retreats, both together hold.
   always_comb begin
      state_next = state;
      case (state)
         EMPTY: begin
            if (push) state_next = ONE;
         end
         ONE: begin
            if (push && !pop)      state_next = FULL;
            else if (pop && !push) state_next = EMPTY;
         end
         FULL: begin
            if (pop) state_next = ONE;
         end
         default: state_next = EMPTY;
      endcase
   end

   // Occupancy state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_next;
   end

   // Arms the input side one edge after reset deasserts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) armed <= 1'b0;
      else        armed <= 1'b1;
   end

   // FIFO storage: pops shift slot 1 into the head, pushes land in the first free slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            p_mem[i] <= '0;
            g_mem[i] <= '0;
            c_mem[i] <= 1'b0;
         end
      end else begin
         if (pop && state == FULL) begin
            p_mem[0] <= p_mem[1];
            g_mem[0] <= g_mem[1];
            c_mem[0] <= c_mem[1];
         end
         if (push) begin
            if (state == EMPTY || (state == ONE && pop)) begin
               p_mem[0] <= p_new;
               g_mem[0] <= g_new;
               c_mem[0] <= cin;
            end else if (state == ONE) begin
               p_mem[1] <= p_new;
               g_mem[1] <= g_new;
               c_mem[1] <= cin;
            end
         end
      end
   end

   // Group generate of the head: ripple the generate term from bit 0 upward.
   always_comb begin
      gg_head = g_mem[0][0];
      for (int i = 1; i < WIDTH; i++) begin
         gg_head = g_mem[0][i] | (p_mem[0][i] & gg_head);
      end
   end

   assign p  = out_valid ? p_mem[0] : '0;
   assign g  = out_valid ? g_mem[0] : '0;
   assign c0 = out_valid ? c_mem[0] : 1'b0;
   assign gp = out_valid ? (&p_mem[0]) : 1'b0;
   assign gg = out_valid ? gg_head : 1'b0;

`ifdef CLA_PG_STALL_CNT_EN
   // Counts cycles where the head is offered but not taken, saturating at all ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= 16'd0;
      end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cla_pg_stage.sv
// tb_cla_pg_stage: directed self-checking bench for cla_pg_stage (WIDTH=8).
`timescale 1ns/1ps

module tb_cla_pg_stage;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] p;
   logic [7:0] g;
   logic       c0;
   logic       gp;
   logic       gg;
`ifdef CLA_PG_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int total;
   int bad;

   cla_pg_stage #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .g         (g),
      .c0        (c0),
      .gp        (gp),
      .gg        (gg)
`ifdef CLA_PG_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic c);
      in_valid = v;
      a        = av;
      b        = bv;
      cin      = c;
   endtask

   task automatic checkHead(input string tag, input logic [7:0] ep, input logic [7:0] eg,
                            input logic ec, input logic egp, input logic egg);
      checkOutput({tag, ".valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, ".p"},     32'(p),   32'(ep));
      checkOutput({tag, ".g"},     32'(g),   32'(eg));
      checkOutput({tag, ".c0"},    32'(c0),  32'(ec));
      checkOutput({tag, ".gp"},    32'(gp),  32'(egp));
      checkOutput({tag, ".gg"},    32'(gg),  32'(egg));
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, ".valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, ".p"},     32'(p),  32'd0);
      checkOutput({tag, ".g"},     32'(g),  32'd0);
      checkOutput({tag, ".c0"},    32'(c0), 32'd0);
      checkOutput({tag, ".gp"},    32'(gp), 32'd0);
      checkOutput({tag, ".gg"},    32'(gg), 32'd0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n     = 1'b0;
      out_ready = 1'b0;
      applyStimulus(1'b1, 8'hFF, 8'h01, 1'b1);

      // Reset state, with a valid request held so nothing must leak in.
      #3;
      checkOutput("rst.in_ready", 32'(in_ready), 32'd0);
      checkIdle("rst");
      tick();
      tick();
      checkOutput("rst2.in_ready", 32'(in_ready), 32'd0);
      checkIdle("rst2");

      // Release reset; the first edge only raises in_ready.
      rst_n = 1'b1;
      tick();
      checkOutput("arm.in_ready", 32'(in_ready), 32'd1);
      checkOutput("arm.no_xfer", 32'(out_valid), 32'd0);
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      checkOutput("arm.still_empty", 32'(out_valid), 32'd0);

      // Basic transfer: 0F+01 -> p=0E g=01; carry dies at bit 4 so gg=0.
      out_ready = 1'b1;
      applyStimulus(1'b1, 8'h0F, 8'h01, 1'b1);
      tick();
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
      checkHead("basic", 8'h0E, 8'h01, 1'b1, 1'b0, 1'b0);
      tick();
      checkIdle("basic.drain");

      // Group propagate: AA^55 all ones.
      applyStimulus(1'b1, 8'hAA, 8'h55, 1'b0);
      tick();
      checkHead("gprop", 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);

      // Back to back: FF+01 propagates g0 to the top, 80+80 generates at the top.
      applyStimulus(1'b1, 8'hFF, 8'h01, 1'b1);
      tick();
      checkHead("ggrip", 8'hFE, 8'h01, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h80, 8'h80, 1'b0);
      tick();
      checkHead("ggtop", 8'h00, 8'h80, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      checkIdle("gg.drain");

      // Backpressure: three pairs offered, only two fit.
      out_ready = 1'b0;
      applyStimulus(1'b1, 8'h01, 8'h00, 1'b0);
      tick();
      checkOutput("bp.ready1", 32'(in_ready), 32'd1);
      checkOutput("bp.head1", 32'(p), 32'h01);
      applyStimulus(1'b1, 8'h02, 8'h00, 1'b1);
      tick();
      checkOutput("bp.ready2", 32'(in_ready), 32'd0);
      applyStimulus(1'b1, 8'h04, 8'h00, 1'b0);
      tick();
      checkOutput("bp.held.ready", 32'(in_ready), 32'd0);
      checkOutput("bp.held.p", 32'(p), 32'h01);
      checkOutput("bp.held.c0", 32'(c0), 32'd0);
      out_ready = 1'b1;
      tick();
      checkOutput("bp.pop1.ready", 32'(in_ready), 32'd1);
      checkOutput("bp.pop1.p", 32'(p), 32'h02);
      checkOutput("bp.pop1.c0", 32'(c0), 32'd1);
      tick();
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
      checkOutput("bp.pop2.valid", 32'(out_valid), 32'd1);
      checkOutput("bp.pop2.p", 32'(p), 32'h04);
      checkOutput("bp.pop2.ready", 32'(in_ready), 32'd1);
      tick();
      checkIdle("bp.drain");

      // Throughput: ten pushes, one output per cycle.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 8'(8'h10 + i), 8'h00, 1'b0);
         tick();
         checkOutput($sformatf("tp%0d.valid", i), 32'(out_valid), 32'd1);
         checkOutput($sformatf("tp%0d.p", i), 32'(p), 32'(8'h10 + i));
         checkOutput($sformatf("tp%0d.ready", i), 32'(in_ready), 32'd1);
      end
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      checkIdle("tp.drain");

      // Reset mid-operation from FULL.
      out_ready = 1'b0;
      applyStimulus(1'b1, 8'hFF, 8'h01, 1'b1);
      tick();
      applyStimulus(1'b1, 8'hF0, 8'hF0, 1'b1);
      tick();
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
      checkOutput("mid.full", 32'(in_ready), 32'd0);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("mid.in_ready", 32'(in_ready), 32'd0);
      checkIdle("mid");
      #2;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick();
      checkIdle("mid.rel1");
      tick();
      checkIdle("mid.rel2");

`ifdef CLA_PG_STALL_CNT_EN
      // Stall counter: one entry held for five edges.
      checkOutput("stall.zero", 32'(stall_cnt), 32'd0);
      out_ready = 1'b0;
      applyStimulus(1'b1, 8'h03, 8'h01, 1'b0);
      tick();
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("stall.five", 32'(stall_cnt), 32'd5);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
